// File: rtl/dshot_command_controller_pkg.sv
// Shared definitions for the DShot command controller: FSM encoding,
// protocol constants and the 4-bit frame checksum.
package dshot_command_controller_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMING   = 2'd1,
    ST_ARMED    = 2'd2,
    ST_FAILSAFE = 2'd3
  } state_t;

  localparam int SPECIAL_CMD_MAX = 47;
  localparam int THROTTLE_OFFSET = 48;

  // v is the 12-bit payload (speed + telemetry bit)
  function automatic logic [3:0] dshot_crc(input logic [11:0] v);
    logic [11:0] x;
    x = v ^ (v >> 4) ^ (v >> 8);
    return x[3:0];
  endfunction

endpackage

// File: rtl/dshot_command_controller_processing.sv
// Purely combinational DShot frame decoder: checksum test and speed-field
// classification into zero / special command / throttle.
module dshotProcessing
  import dshot_command_controller_pkg::*;
(
  input  logic [15:0] i_frame_data,
  output logic        o_crc_ok,
  output logic        o_telem,
  output logic        o_is_zero,
  output logic        o_is_cmd,
  output logic [5:0]  o_cmd,
  output logic [10:0] o_throttle
);

  logic [10:0] w_speed;

  assign w_speed    = i_frame_data[15:5];
  assign o_telem    = i_frame_data[4];
  assign o_crc_ok   = (dshot_crc(i_frame_data[15:4]) == i_frame_data[3:0]);
  assign o_is_zero  = (w_speed == 11'd0);
  assign o_is_cmd   = (w_speed != 11'd0) && (w_speed <= 11'(SPECIAL_CMD_MAX));
  assign o_cmd      = w_speed[5:0];
  // only meaningful when the frame is neither zero nor a command
  assign o_throttle = w_speed - 11'(THROTTLE_OFFSET);

endmodule

// File: rtl/dshot_command_controller.sv
// DShot command controller: arming sequence, throttle hold, special-command
// qualification by repetition, link timeout and failsafe.
module dshot_command_controller
  import dshot_command_controller_pkg::*;
#(
  parameter int ARM_FRAMES     = 10,
  parameter int CMD_REPEAT     = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_valid,
  input  logic [15:0] frame_data,
  output logic [10:0] throttle,
  output logic        throttle_valid,
  output logic [5:0]  cmd_out,
  output logic        cmd_valid,
  output logic        telem_req,
  output logic        armed,
  output logic        failsafe,
  output logic [7:0]  crc_err_count
);

  localparam int AW = $clog2(ARM_FRAMES + 1);
  localparam int RW = $clog2(CMD_REPEAT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic        w_crc_ok;
  logic        w_telem;
  logic        w_is_zero;
  logic        w_is_cmd;
  logic [5:0]  w_cmd;
  logic [10:0] w_throttle_dec;

  dshotProcessing u_decode (
    .i_frame_data (frame_data),
    .o_crc_ok     (w_crc_ok),
    .o_telem      (w_telem),
    .o_is_zero    (w_is_zero),
    .o_is_cmd     (w_is_cmd),
    .o_cmd        (w_cmd),
    .o_throttle   (w_throttle_dec)
  );

  state_t        r_state, w_state_next;
  logic [AW-1:0] r_arm_cnt, w_arm_cnt_next;
  logic [RW-1:0] r_rep_cnt, w_rep_cnt_next;
  logic [5:0]    r_last_cmd, w_last_cmd_next;
  logic [TW-1:0] r_timer, w_timer_next;
  logic [10:0]   r_throttle, w_throttle_next;
  logic          r_throttle_valid, w_throttle_valid_next;
  logic [5:0]    r_cmd_out, w_cmd_out_next;
  logic          r_cmd_valid, w_cmd_valid_next;
  logic          r_telem_req, w_telem_req_next;
  logic [7:0]    r_crc_err, w_crc_err_next;

  logic w_frame_ok;
  logic w_expired;

  assign w_frame_ok = frame_valid && w_crc_ok;
  // expiry is the decrement from 1 to 0; a good frame in that cycle wins
  assign w_expired  = !w_frame_ok && (r_timer == TW'(1));

  always_comb begin
    w_state_next          = r_state;
    w_arm_cnt_next        = r_arm_cnt;
    w_rep_cnt_next        = r_rep_cnt;
    w_last_cmd_next       = r_last_cmd;
    w_timer_next          = r_timer;
    w_throttle_next       = r_throttle;
    w_throttle_valid_next = 1'b0;
    w_cmd_out_next        = r_cmd_out;
    w_cmd_valid_next      = 1'b0;
    w_telem_req_next      = 1'b0;
    w_crc_err_next        = r_crc_err;

    if (frame_valid && !w_crc_ok && (r_crc_err != 8'hFF)) begin
      w_crc_err_next = r_crc_err + 8'd1;
    end

    if (w_frame_ok) begin
      w_timer_next = TW'(TIMEOUT_CYCLES);
    end else if (r_timer != '0) begin
      w_timer_next = r_timer - TW'(1);
    end

    case (r_state)
      ST_DISARMED, ST_FAILSAFE: begin
        if (w_frame_ok && w_is_zero) begin
          if (ARM_FRAMES <= 1) begin
            w_state_next   = ST_ARMED;
            w_arm_cnt_next = '0;
          end else begin
            w_state_next   = ST_ARMING;
            w_arm_cnt_next = AW'(1);
          end
        end
      end

      ST_ARMING: begin
        if (w_frame_ok) begin
          if (w_is_zero) begin
            if (int'(r_arm_cnt) + 1 >= ARM_FRAMES) begin
              w_state_next   = ST_ARMED;
              w_arm_cnt_next = '0;
            end else begin
              w_arm_cnt_next = r_arm_cnt + AW'(1);
            end
          end else begin
            w_state_next   = ST_DISARMED;
            w_arm_cnt_next = '0;
          end
        end else if (w_expired) begin
          w_state_next   = ST_DISARMED;
          w_arm_cnt_next = '0;
        end
      end

      ST_ARMED: begin
        if (w_frame_ok) begin
          w_telem_req_next = w_telem;
          if (w_is_zero) begin
            w_throttle_next       = 11'd0;
            w_throttle_valid_next = 1'b1;
            w_rep_cnt_next        = '0;
          end else if (w_is_cmd) begin
            if ((r_rep_cnt != '0) && (w_cmd == r_last_cmd)) begin
              // saturates at CMD_REPEAT so a held command fires only once
              if (int'(r_rep_cnt) < CMD_REPEAT) begin
                w_rep_cnt_next = r_rep_cnt + RW'(1);
                if (int'(r_rep_cnt) + 1 == CMD_REPEAT) begin
                  w_cmd_out_next   = w_cmd;
                  w_cmd_valid_next = 1'b1;
                end
              end
            end else begin
              w_rep_cnt_next  = RW'(1);
              w_last_cmd_next = w_cmd;
              if (CMD_REPEAT <= 1) begin
                w_cmd_out_next   = w_cmd;
                w_cmd_valid_next = 1'b1;
              end
            end
          end else begin
            w_throttle_next       = w_throttle_dec;
            w_throttle_valid_next = 1'b1;
            w_rep_cnt_next        = '0;
          end
        end else if (w_expired) begin
          w_state_next          = ST_FAILSAFE;
          w_throttle_next       = 11'd0;
          w_throttle_valid_next = 1'b1;
          w_rep_cnt_next        = '0;
        end
      end

      default: begin
        w_state_next = ST_DISARMED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= ST_DISARMED;
      r_arm_cnt        <= '0;
      r_rep_cnt        <= '0;
      r_last_cmd       <= '0;
      r_timer          <= TW'(TIMEOUT_CYCLES);
      r_throttle       <= '0;
      r_throttle_valid <= 1'b0;
      r_cmd_out        <= '0;
      r_cmd_valid      <= 1'b0;
      r_telem_req      <= 1'b0;
      r_crc_err        <= '0;
    end else begin
      r_state          <= w_state_next;
      r_arm_cnt        <= w_arm_cnt_next;
      r_rep_cnt        <= w_rep_cnt_next;
      r_last_cmd       <= w_last_cmd_next;
      r_timer          <= w_timer_next;
      r_throttle       <= w_throttle_next;
      r_throttle_valid <= w_throttle_valid_next;
      r_cmd_out        <= w_cmd_out_next;
      r_cmd_valid      <= w_cmd_valid_next;
      r_telem_req      <= w_telem_req_next;
      r_crc_err        <= w_crc_err_next;
    end
  end

  assign throttle       = r_throttle;
  assign throttle_valid = r_throttle_valid;
  assign cmd_out        = r_cmd_out;
  assign cmd_valid      = r_cmd_valid;
  assign telem_req      = r_telem_req;
  assign armed          = (r_state == ST_ARMED);
  assign failsafe       = (r_state == ST_FAILSAFE);
  assign crc_err_count  = r_crc_err;

endmodule

// File: tb/tb_dshot_command_controller.sv
// Directed self-checking bench for dshot_command_controller (short timeout).
module tb_dshot_command_controller;

  localparam int T = 2000;

  logic        clk;
  logic        rst_n;
  logic        frame_valid;
  logic [15:0] frame_data;
  logic [10:0] throttle;
  logic        throttle_valid;
  logic [5:0]  cmd_out;
  logic        cmd_valid;
  logic        telem_req;
  logic        armed;
  logic        failsafe;
  logic [7:0]  crc_err_count;

  int total = 0;
  int bad   = 0;

  dshot_command_controller #(
    .ARM_FRAMES     (10),
    .CMD_REPEAT     (6),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_valid    (frame_valid),
    .frame_data     (frame_data),
    .throttle       (throttle),
    .throttle_valid (throttle_valid),
    .cmd_out        (cmd_out),
    .cmd_valid      (cmd_valid),
    .telem_req      (telem_req),
    .armed          (armed),
    .failsafe       (failsafe),
    .crc_err_count  (crc_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // drive one frame for a single cycle; returns at the following negedge,
  // where the registered response to that frame is visible
  task automatic send(input logic [15:0] f);
    @(negedge clk);
    frame_valid = 1'b1;
    frame_data  = f;
    @(negedge clk);
    frame_valid = 1'b0;
    frame_data  = 16'h0000;
    $display("tx frame=%h thr=%0d tv=%0b cmd=%0d cv=%0b tr=%0b armed=%0b fs=%0b crc=%0d",
             f, throttle, throttle_valid, cmd_out, cmd_valid, telem_req, armed, failsafe,
             crc_err_count);
  endtask

  task automatic send_n(input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) send(f);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_valid = 1'b0;
    frame_data  = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check("rst_throttle", throttle, 0);
    check("rst_tv", throttle_valid, 0);
    check("rst_cmd_out", cmd_out, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_telem", telem_req, 0);
    check("rst_armed", armed, 0);
    check("rst_failsafe", failsafe, 0);
    check("rst_crc", crc_err_count, 0);

    // arming aborted by a nonzero frame, then a full arm sequence
    send_n(16'h0000, 9);
    check("arm9_armed", armed, 0);
    send(16'h82C6);
    check("abort_armed", armed, 0);
    check("abort_tv", throttle_valid, 0);
    check("abort_thr", throttle, 0);
    send_n(16'h0000, 9);
    check("rearm9_armed", armed, 0);
    send(16'h0000);
    check("arm10_armed", armed, 1);

    // throttle
    send(16'h82C6);
    check("thr998", throttle, 998);
    check("thr998_tv", throttle_valid, 1);
    @(negedge clk);
    check("tv_one_cycle", throttle_valid, 0);
    send(16'hFFEE);
    check("thr1999", throttle, 1999);
    check("thr1999_tv", throttle_valid, 1);

    // CRC errors
    send(16'h82C5);
    check("crc_thr_hold", throttle, 1999);
    check("crc_tv", throttle_valid, 0);
    check("crc_cnt1", crc_err_count, 1);
    send_n(16'h82C5, 300);
    check("crc_sat", crc_err_count, 255);
    check("crc_armed", armed, 1);

    // command qualification
    send_n(16'h00EE, 5);
    check("cmd5_cv", cmd_valid, 0);
    send(16'h00EE);
    check("cmd6_cv", cmd_valid, 1);
    check("cmd6_out", cmd_out, 7);
    check("cmd6_thr", throttle, 1999);
    check("cmd6_tv", throttle_valid, 0);
    send(16'h00EE);
    check("cmd7_cv", cmd_valid, 0);
    send(16'h0000);
    check("zero_thr", throttle, 0);
    check("zero_tv", throttle_valid, 1);
    send_n(16'h00EE, 5);
    send(16'h0000);
    send(16'h00EE);
    check("broken_cv", cmd_valid, 0);
    send_n(16'h00EE, 4);
    check("run5_cv", cmd_valid, 0);
    send(16'h00EE);
    check("run6_cv", cmd_valid, 1);

    // telemetry request with zero throttle
    send(16'h0011);
    check("telem_req", telem_req, 1);
    check("telem_thr", throttle, 0);
    check("telem_tv", throttle_valid, 1);
    @(negedge clk);
    check("telem_one_cycle", telem_req, 0);

    // frame landing on the expiry cycle keeps the link alive
    send(16'h82C6);
    check("pre_to_thr", throttle, 998);
    repeat (T - 2) @(negedge clk);
    send(16'h82C6);
    check("edge_failsafe", failsafe, 0);
    check("edge_armed", armed, 1);
    check("edge_tv", throttle_valid, 1);

    // timeout into failsafe
    repeat (T - 1) @(negedge clk);
    check("to_before_fs", failsafe, 0);
    check("to_before_thr", throttle, 998);
    @(negedge clk);
    check("to_failsafe", failsafe, 1);
    check("to_armed", armed, 0);
    check("to_thr", throttle, 0);
    check("to_tv", throttle_valid, 1);
    @(negedge clk);
    check("to_tv_once", throttle_valid, 0);
    check("to_fs_hold", failsafe, 1);

    // recovery from failsafe
    send(16'h0000);
    check("rec1_failsafe", failsafe, 0);
    check("rec1_armed", armed, 0);
    send_n(16'h0000, 8);
    check("rec9_armed", armed, 0);
    send(16'h0000);
    check("rec10_armed", armed, 1);
    check("rec10_failsafe", failsafe, 0);

    // reset mid-qualification discards partial counts
    send_n(16'h00EE, 5);
    do_reset();
    check("mid_rst_cv", cmd_valid, 0);
    check("mid_rst_armed", armed, 0);
    check("mid_rst_crc", crc_err_count, 0);
    send_n(16'h0000, 5);
    do_reset();
    send_n(16'h0000, 5);
    check("mid_rst_arm5", armed, 0);
    send_n(16'h0000, 5);
    check("mid_rst_arm10", armed, 1);
    send(16'h00EE);
    check("mid_rst_cmd1", cmd_valid, 0);
    send_n(16'h00EE, 5);
    check("mid_rst_cmd6", cmd_valid, 1);
    check("mid_rst_cmd_out", cmd_out, 7);

    // timeout while arming falls back to disarmed
    do_reset();
    send_n(16'h0000, 3);
    repeat (T) @(negedge clk);
    check("arming_to_fs", failsafe, 0);
    send_n(16'h0000, 7);
    check("arming_to_armed", armed, 0);
    send_n(16'h0000, 3);
    check("arming_to_rearm", armed, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dshot_command_controller.md
DSHOT_COMMAND_CONTROLLER -- requirements
Module: dshot_command_controller

Interface
REQ-001 Parameter ARM_FRAMES, default 10: the number of consecutive valid zero-throttle frames required to arm.
REQ-002 Parameter CMD_REPEAT, default 6: the number of consecutive identical special-command frames required to accept a command.
REQ-003 Parameter TIMEOUT_CYCLES, default 100000: the number of clock cycles without a valid frame before timeout.
REQ-004 clk  input  1  sole clock; all logic SHALL be on the rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 frame_valid  input  1  one-cycle strobe marking a new received frame.
REQ-007 frame_data  input  16  raw DShot frame: [15:5] speed, [4] telemetry, [3:0] CRC.
REQ-008 throttle  output  11  held throttle command, range 0..1999.
REQ-009 throttle_valid  output  1  one-cycle pulse on each throttle update.
REQ-010 cmd_out  output  6  last accepted special command, range 1..47.
REQ-011 cmd_valid  output  1  one-cycle pulse on command acceptance.
REQ-012 telem_req  output  1  one-cycle pulse when an accepted frame in ARMED has telemetry=1.
REQ-013 armed  output  1  high in ARMED only.
REQ-014 failsafe  output  1  high in FAILSAFE only.
REQ-015 crc_err_count  output  8  saturating count of CRC-failed frames.

Function
REQ-016 Frame decode SHALL be combinational, using CRC = (v ^ v>>4 ^ v>>8) & 0xF, where v = frame_data[15:4].
REQ-017 A frame SHALL be "valid" when frame_valid=1 and its CRC matches; all outputs SHALL be registered, with 1-cycle latency from frame_valid.
REQ-018 A CRC-failed frame SHALL increment crc_err_count (saturating at 255) and SHALL NOT affect state, counters, or the timer.
REQ-019 FSM states SHALL be DISARMED, ARMING, ARMED, FAILSAFE.
REQ-020 DISARMED: a valid frame with speed=0 SHALL go to ARMING with arm_cnt=1; all other frames SHALL be ignored.
REQ-021 ARMING: a valid speed=0 frame SHALL increment arm_cnt; when arm_cnt reaches ARM_FRAMES, the FSM SHALL go to ARMED; any valid nonzero frame SHALL go to DISARMED with arm_cnt cleared.
REQ-022 ARMED, speed 48..2047: throttle SHALL equal speed-48 and throttle_valid SHALL pulse.
REQ-023 ARMED, speed 0: throttle SHALL be 0 and throttle_valid SHALL pulse.
REQ-024 ARMED, speed 1..47: these frames SHALL be command candidates; throttle SHALL be unchanged.
REQ-025 Command qualification SHALL work as follows: rep_cnt counts consecutive identical command frames; cmd_valid pulses and cmd_out updates when rep_cnt reaches CMD_REPEAT; further identical frames SHALL NOT re-fire until a different valid frame intervenes; any different valid frame SHALL reset rep_cnt (to 1 if it is itself a command).
REQ-026 The timer SHALL reload on every valid frame and decrement otherwise.
REQ-027 On timer expiry, ARMED SHALL go to FAILSAFE, and ARMING SHALL go to DISARMED.
REQ-028 On entry to FAILSAFE, throttle SHALL be forced to 0 with one throttle_valid pulse.
REQ-029 FAILSAFE: a valid speed=0 frame SHALL go to ARMING with arm_cnt=1; other frames SHALL be ignored.
REQ-030 If a valid frame and timer expiry occur in the same cycle, the frame SHALL win: the timer reloads and no timeout occurs.
REQ-031 On any state exit from ARMED, rep_cnt SHALL clear.

Reset
REQ-032 While rst_n=0 at a clock edge, the FSM SHALL be DISARMED; throttle=0, cmd_out=0, all pulses=0, armed=0, failsafe=0, crc_err_count=0, arm_cnt=0, rep_cnt=0, timer=TIMEOUT_CYCLES.
REQ-033 A reset asserted mid-qualification SHALL discard partial arm and command counts with no output pulse.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, the constants SPECIAL_CMD_MAX=47 and THROTTLE_OFFSET=48, and the CRC function.
REQ-035 The existing combinational decoder dshotProcessing SHALL be the single instantiated sub-module; the controller SHALL contain no duplicate decode logic.

Verification
REQ-036 Arm sequence: after reset, 10 frames of 0x0000 -> armed=1 one cycle after the 10th; 9 frames then one 0x82C6 -> armed stays 0, state DISARMED.
REQ-037 Throttle: armed, send 0x82C6 -> throttle=998 with a throttle_valid pulse; send 0xFFEE -> throttle=1999.
REQ-038 CRC error: armed, send 0x82C5 -> throttle unchanged, crc_err_count +1; send 300 bad frames -> crc_err_count=255.
REQ-039 Command: armed, send 0x00EE six times -> cmd_valid pulses once with cmd_out=7; a 7th 0x00EE -> no pulse; 5x 0x00EE then 0x0000 then 0x00EE -> no pulse.
REQ-040 Failsafe: armed at throttle 998, no frames for 100000 cycles -> failsafe=1, armed=0, throttle=0; then 10x 0x0000 -> armed=1, failsafe=0.
REQ-041 Edge cases: a frame on the expiry cycle -> no failsafe; armed, 0x0011 -> telem_req pulse with throttle=0.
